mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares the single RAM port between the core's instruction-fetch requester (if_*) and its
//   load/store requester (d_*).
// - Sequences each access: arbitration, address issue, fixed-latency read wait, response.
// - Sits between the core and the RAM. Owns ram_adress, data_out_ram and ram_enable_write.
// PARAMETERS
// - ADDR_W      32  address width, all address ports
// - DATA_W      32  data width, all data ports
// - RD_LATENCY  1   cycles from address presented to data_in_ram valid; legal range 1..8
// PORTS
// - clk               in   1       system clock, all state on posedge
// - rst_n             in   1       asynchronous, active-low reset
// - if_req            in   1       fetch request; hold with if_addr stable until if_gnt
// - if_addr           in   ADDR_W  fetch address
// - if_gnt            out  1       one-cycle pulse: fetch request accepted
// - if_rvalid         out  1       one-cycle pulse: if_rdata valid
// - if_rdata          out  DATA_W  fetch read data; holds its value between pulses
// - d_req             in   1       data request; hold d_we/d_addr/d_wdata stable until d_gnt
// - d_we              in   1       1 = store, 0 = load
// - d_addr            in   ADDR_W  data address
// - d_wdata           in   DATA_W  store data
// - d_gnt             out  1       one-cycle pulse: data request accepted
// - d_rvalid          out  1       one-cycle pulse, loads only: d_rdata valid
// - d_rdata           out  DATA_W  load read data; holds its value between pulses
// - ram_adress        out  ADDR_W  RAM address; holds last value when idle
// - data_out_ram      out  DATA_W  RAM write data; holds last value when idle
// - ram_enable_write  out  1       RAM write strobe; high for exactly one cycle per store
// - data_in_ram       in   DATA_W  RAM read data
// - busy              out  1       state != IDLE
// BEHAVIOUR
// - Reset (async, rst_n low): state=IDLE, last_winner=IF.
//   All outputs 0: gnt, rvalid, rdata, ram_adress, data_out_ram, ram_enable_write, busy.
// - All outputs are registered. FSM states: IDLE, ISSUE, WAIT, RESP.
// - IDLE: requests sampled only in this state. If any req is high at the edge:
//   - latch the winner, its address, d_we and d_wdata;
//   - load ram_adress/data_out_ram; set ram_enable_write=d_we if data won;
//   - go to ISSUE. No req: stay in IDLE.
// - ISSUE (cycle T, 1 cycle): winner's gnt=1 and the address is on the RAM.
//   - store: ram_enable_write=1 in T only -> IDLE; no rvalid.
//   - load/fetch: -> WAIT, cnt=RD_LATENCY-1.
// - WAIT (cycles T+1..T+RD_LATENCY): decrement cnt.
//   - At the end of cycle T+RD_LATENCY, capture data_in_ram into the winner's rdata -> RESP.
// - RESP (T+RD_LATENCY+1): winner's rvalid=1 for one cycle -> IDLE.
// - Latency: req seen in IDLE at T-1 -> gnt at T -> rvalid at T+RD_LATENCY+1.
// - Throughput: a read occupies RD_LATENCY+3 cycles (including the IDLE cycle); a store occupies 2.
// - The loser keeps its req high and is considered at the next IDLE. Its gnt stays 0.
// - A req dropped after latch: the access still completes (protocol violation, not masked).
// - Only one transaction is in flight; if_gnt and d_gnt are never high together.
// - last_winner updates on every ISSUE.
// - Reset mid-operation (any state): the in-flight access is abandoned.
//   No rvalid after release; next request is served normally from IDLE.
// - RD_LATENCY outside 1..8: elaboration error.
// CONFIGURATION
// - MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority; when both req in IDLE, d_* always wins
//   (fetch may starve).
// - MEM_ARB_ROUND_ROBIN_EN defined: when both req in IDLE, the requester != last_winner wins.
//   A single requester always wins regardless of last_winner.
// TESTING
// - RD_LATENCY=1, if_req=1, if_addr=0x10, RAM returns 0xDEADBEEF -> if_gnt at T,
//   ram_adress=0x10, if_rvalid at T+2 with if_rdata=0xDEADBEEF, d_gnt never high.
// - d_req=1, d_we=1, d_addr=0x40, d_wdata=0x1234 -> d_gnt at T, ram_enable_write=1 only at T,
//   ram_adress=0x40, data_out_ram=0x1234, no d_rvalid, busy low at T+1.
// - Fixed priority: if_req and d_req (load) held high for 4 accesses -> d_gnt x4, if_gnt=0,
//   d_rvalid x4.
// - MEM_ARB_ROUND_ROBIN_EN: both held high from reset -> grant order d, if, d, if.
// - RD_LATENCY=3, load at 0x8 -> d_gnt at T, d_rvalid at T+4 with data_in_ram sampled end of T+3.
// - rst_n pulsed low during WAIT of a fetch -> all outputs 0 immediately, no if_rvalid after release;
//   next if_req gets if_gnt 1 cycle later.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch (if_*) and load/store (d_*) requesters.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of data-first fixed priority.
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic [ADDR_W-1:0] ram_adress,
   output logic [DATA_W-1:0] data_out_ram,
   output logic              ram_enable_write,
   input  logic [DATA_W-1:0] data_in_ram,
   output logic              busy
);

   if (RD_LATENCY < 1 || RD_LATENCY > 8) begin : g_bad_latency
      $error("mem_port_arbiter: RD_LATENCY must be in 1..8");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [2:0] CNT_INIT = 3'(RD_LATENCY - 1);

   state_t     state, state_nxt;
   logic       win_d;      // current owner: 1 = data port, 0 = fetch port
   logic       last_d;     // previous owner, for round-robin
   logic       is_store;
   logic [2:0] cnt;
   logic       any_req;
   logic       pick_d;

   always_comb begin
      any_req = if_req | d_req;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      pick_d  = d_req & (~if_req | ~last_d);
`else
      pick_d  = d_req;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = ISSUE;
         ISSUE:   state_nxt = is_store ? IDLE : WAIT;
         WAIT:    if (cnt == 3'd0) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_d            <= 1'b0;
         last_d           <= 1'b0;
         is_store         <= 1'b0;
         cnt              <= 3'd0;
         if_gnt           <= 1'b0;
         d_gnt            <= 1'b0;
         if_rvalid        <= 1'b0;
         d_rvalid         <= 1'b0;
         if_rdata         <= '0;
         d_rdata          <= '0;
         ram_adress       <= '0;
         data_out_ram     <= '0;
         ram_enable_write <= 1'b0;
         busy             <= 1'b0;
      end else begin
         if_gnt           <= 1'b0;
         d_gnt            <= 1'b0;
         if_rvalid        <= 1'b0;
         d_rvalid         <= 1'b0;
         ram_enable_write <= 1'b0;
         busy             <= (state_nxt != IDLE);
         case (state)
            IDLE: if (any_req) begin
               win_d            <= pick_d;
               is_store         <= pick_d & d_we;
               ram_adress       <= pick_d ? d_addr : if_addr;
               if (pick_d) data_out_ram <= d_wdata;
               ram_enable_write <= pick_d & d_we;
               if_gnt           <= ~pick_d;
               d_gnt            <= pick_d;
            end
            ISSUE: begin
               last_d <= win_d;
               cnt    <= CNT_INIT;
            end
            WAIT: begin
               cnt <= cnt - 3'd1;
               // Last wait cycle: RAM data is valid now, present it next cycle.
               if (cnt == 3'd0) begin
                  if (win_d) begin
                     d_rdata  <= data_in_ram;
                     d_rvalid <= 1'b1;
                  end else begin
                     if_rdata  <= data_in_ram;
                     if_rvalid <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: two instances (RD_LATENCY 1 and 3) against a
// per-instance transaction-timeline reference model.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req [2];
   logic [31:0] if_addr [2];
   logic        d_req [2];
   logic        d_we [2];
   logic [31:0] d_addr [2];
   logic [31:0] d_wdata [2];
   logic [31:0] data_in_ram;
   logic        if_gnt [2], if_rvalid [2], d_gnt [2], d_rvalid [2];
   logic        ram_enable_write [2], busy [2];
   logic [31:0] if_rdata [2], d_rdata [2], ram_adress [2], data_out_ram [2];

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(1)) u0 (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req[0]), .if_addr(if_addr[0]), .if_gnt(if_gnt[0]),
      .if_rvalid(if_rvalid[0]), .if_rdata(if_rdata[0]),
      .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
      .d_gnt(d_gnt[0]), .d_rvalid(d_rvalid[0]), .d_rdata(d_rdata[0]),
      .ram_adress(ram_adress[0]), .data_out_ram(data_out_ram[0]),
      .ram_enable_write(ram_enable_write[0]), .data_in_ram(data_in_ram), .busy(busy[0]));

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LATENCY(3)) u1 (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req[1]), .if_addr(if_addr[1]), .if_gnt(if_gnt[1]),
      .if_rvalid(if_rvalid[1]), .if_rdata(if_rdata[1]),
      .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
      .d_gnt(d_gnt[1]), .d_rvalid(d_rvalid[1]), .d_rdata(d_rdata[1]),
      .ram_adress(ram_adress[1]), .data_out_ram(data_out_ram[1]),
      .ram_enable_write(ram_enable_write[1]), .data_in_ram(data_in_ram), .busy(busy[1]));

   int n_chk = 0;
   int n_err = 0;

   // Model: age = cycles since grant (-1 when no access owns the port).
   int          age [2];
   bit          m_wd [2], m_st [2], m_last_d [2];
   bit          e_ig [2], e_dg [2], e_irv [2], e_drv [2], e_we [2], e_busy [2];
   logic [31:0] e_ird [2], e_drd [2], e_addr [2], e_wd [2];

   bit hold, rnd;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic int lat(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         age[k] = -1; m_wd[k] = 0; m_st[k] = 0; m_last_d[k] = 0;
         e_ig[k] = 0; e_dg[k] = 0; e_irv[k] = 0; e_drv[k] = 0; e_we[k] = 0; e_busy[k] = 0;
         e_ird[k] = '0; e_drd[k] = '0; e_addr[k] = '0; e_wd[k] = '0;
      end
   endtask

   task automatic model_step(input int k);
      bit pd;
      e_ig[k] = 0; e_dg[k] = 0; e_irv[k] = 0; e_drv[k] = 0; e_we[k] = 0;
      if (age[k] < 0) begin
         if (if_req[k] || d_req[k]) begin
            if (if_req[k] && d_req[k]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
               pd = !m_last_d[k];
`else
               pd = 1;
`endif
            end else pd = d_req[k];
            m_wd[k] = pd; m_st[k] = pd && d_we[k]; m_last_d[k] = pd;
            e_addr[k] = pd ? d_addr[k] : if_addr[k];
            if (pd) e_wd[k] = d_wdata[k];
            e_we[k] = m_st[k]; e_ig[k] = !pd; e_dg[k] = pd;
            age[k] = 0; e_busy[k] = 1;
         end else e_busy[k] = 0;
      end else if (age[k] == 0) begin
         if (m_st[k]) begin age[k] = -1; e_busy[k] = 0; end
         else age[k] = 1;
      end else if (age[k] < lat(k)) begin
         age[k]++;
      end else if (age[k] == lat(k)) begin
         if (m_wd[k]) begin e_drd[k] = data_in_ram; e_drv[k] = 1; end
         else begin e_ird[k] = data_in_ram; e_irv[k] = 1; end
         age[k]++;
      end else begin
         age[k] = -1; e_busy[k] = 0;
      end
   endtask

   task automatic check_all(input int k);
      chk($sformatf("u%0d.if_gnt", k), if_gnt[k], e_ig[k]);
      chk($sformatf("u%0d.d_gnt", k), d_gnt[k], e_dg[k]);
      chk($sformatf("u%0d.if_rvalid", k), if_rvalid[k], e_irv[k]);
      chk($sformatf("u%0d.d_rvalid", k), d_rvalid[k], e_drv[k]);
      chk($sformatf("u%0d.if_rdata", k), if_rdata[k], e_ird[k]);
      chk($sformatf("u%0d.d_rdata", k), d_rdata[k], e_drd[k]);
      chk($sformatf("u%0d.ram_adress", k), ram_adress[k], e_addr[k]);
      chk($sformatf("u%0d.data_out_ram", k), data_out_ram[k], e_wd[k]);
      chk($sformatf("u%0d.ram_we", k), ram_enable_write[k], e_we[k]);
      chk($sformatf("u%0d.busy", k), busy[k], e_busy[k]);
   endtask

   // Requester behaviour: hold until granted, then drop (or renew when hold is set).
   task automatic drive(input int k);
      if (e_ig[k]) begin
         if_req[k] = hold;
         if (hold) if_addr[k] = $urandom;
      end
      if (e_dg[k]) begin
         d_req[k] = hold;
         if (hold) d_addr[k] = $urandom;
      end
      if (rnd) begin
         if (!if_req[k] && $urandom_range(0, 2) == 0) begin
            if_req[k] = 1; if_addr[k] = $urandom;
         end
         if (!d_req[k] && $urandom_range(0, 2) == 0) begin
            d_req[k] = 1; d_we[k] = 1'($urandom); d_addr[k] = $urandom; d_wdata[k] = $urandom;
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step(0);
      model_step(1);
      @(negedge clk);
      check_all(0);
      check_all(1);
      drive(0);
      drive(1);
      if (rnd) data_in_ram = $urandom;
   endtask

   initial begin
      int guard;
      rst_n = 1'b0;
      hold = 0; rnd = 0;
      data_in_ram = 32'hDEAD_BEEF;
      for (int k = 0; k < 2; k++) begin
         if_req[k] = 0; if_addr[k] = '0; d_req[k] = 0; d_we[k] = 0; d_addr[k] = '0; d_wdata[k] = '0;
      end
      model_reset();
      #3;
      check_all(0);
      check_all(1);
      @(negedge clk);
      rst_n = 1'b1;

      // Fetch at 0x10, RAM returns 0xDEADBEEF.
      for (int k = 0; k < 2; k++) begin if_req[k] = 1; if_addr[k] = 32'h10; end
      repeat (8) cycle();

      // Store 0x1234 to 0x40.
      for (int k = 0; k < 2; k++) begin
         d_req[k] = 1; d_we[k] = 1; d_addr[k] = 32'h40; d_wdata[k] = 32'h1234;
      end
      repeat (6) cycle();

      // Both requesters continuously loading/fetching.
      hold = 1;
      for (int k = 0; k < 2; k++) begin
         if_req[k] = 1; if_addr[k] = 32'h100; d_req[k] = 1; d_we[k] = 0; d_addr[k] = 32'h200;
      end
      repeat (30) cycle();
      hold = 0;
      repeat (15) cycle();

      rnd = 1;
      repeat (2000) cycle();
      rnd = 0;
      repeat (40) cycle();

      // Reset in the middle of a fetch's read wait.
      data_in_ram = 32'hCAFE_F00D;
      for (int k = 0; k < 2; k++) begin if_req[k] = 1; if_addr[k] = 32'h80; end
      guard = 0;
      while (age[1] != 1 && guard < 20) begin
         cycle();
         guard++;
      end
      chk("rst_wait_busy", busy[1], 1'b1);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all(0);
      check_all(1);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 2; k++) begin if_req[k] = 1; if_addr[k] = 32'h84; end
      repeat (10) cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
